os_rom_arb: RTL and testbench

Two-port arbiter that shares the single synchronous 16-bit startup-program ROM (1 Kword, 1-cycle registered read) between two requesters: port 0 (68000 bus interface) and port 1 (boot loader / copy engine). It serialises accesses with round-robin priority, drives the ROM address, captures the returned word, and completes each access with a one-cycle acknowledge. It sits between the requesters and the ROM instance in the 25drv top level.

---
 rtl/os_rom_arb.sv | 122 ++++++++++++
 tb/tb_os_rom_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_rom_arb.sv
// Round-robin arbiter sharing one 1-cycle-latency 16-bit startup ROM between two
// requesters. Each access completes with a one-cycle ack and the captured word.
module os_rom_arb #(
  parameter logic [15:0] OOR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [11:0] addr0,
  output logic        ack0,
  output logic [15:0] rdata0,
  input  logic        req1,
  input  logic [11:0] addr1,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_reg, state_next;
  logic        gnt_reg, gnt_next;
  logic        last_grant_reg, last_grant_next;
  logic        oor_reg, oor_next;
  logic [9:0]  rom_addr_reg, rom_addr_next;

  logic [1:0]  req_vec;
  logic [1:0]  ack_vec;
  logic [1:0]  eff;
  logic [11:0] addr_vec [2];
  logic [15:0] rdata_vec [2];
  logic        sel;
  logic        unused_addr_lsb;

  assign req_vec     = {req1, req0};
  assign addr_vec[0] = addr0;
  assign addr_vec[1] = addr1;
  assign unused_addr_lsb = addr0[0] ^ addr1[0];

  // A port in its own ack cycle is still dropping req; never re-grant it there.
  assign eff = req_vec & ~ack_vec;

  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    last_grant_next = last_grant_reg;
    oor_next        = oor_reg;
    rom_addr_next   = rom_addr_reg;
    sel             = (eff == 2'b11) ? ~last_grant_reg : eff[1];
    case (state_reg)
      IDLE: begin
        if (|eff) begin
          gnt_next        = sel;
          last_grant_next = sel;
          if (addr_vec[sel][11]) begin
            oor_next   = 1'b1;
            state_next = DATA;
          end else begin
            rom_addr_next = addr_vec[sel][10:1];
            state_next    = ADDR;
          end
        end
      end
      ADDR: state_next = DATA;
      DATA: begin
        oor_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      gnt_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      oor_reg        <= 1'b0;
      rom_addr_reg   <= 10'd0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      last_grant_reg <= last_grant_next;
      oor_reg        <= oor_next;
      rom_addr_reg   <= rom_addr_next;
    end
  end

  // Per-port completion: only the granted port's ack/rdata change in DATA.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic        ack_reg;
    logic [15:0] rdata_reg;
    logic        hit;

    assign hit = (state_reg == DATA) && (gnt_reg == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_reg   <= 1'b0;
        rdata_reg <= 16'd0;
      end else begin
        ack_reg <= hit;
        if (hit) begin
          rdata_reg <= oor_reg ? OOR_DATA : rom_data;
        end
      end
    end

    assign ack_vec[gi]   = ack_reg;
    assign rdata_vec[gi] = rdata_reg;
  end

  assign ack0     = ack_vec[0];
  assign ack1     = ack_vec[1];
  assign rdata0   = rdata_vec[0];
  assign rdata1   = rdata_vec[1];
  assign rom_addr = rom_addr_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_os_rom_arb.sv
// Bench for os_rom_arb: directed vector table, contention and reset sequences, and
// random two-port traffic checked every cycle against a schedule-level service model.
module tb_os_rom_arb;

  localparam logic [15:0] OOR = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rq = 2'b00;
  logic [11:0] ad [2];
  logic [1:0]  ack;
  logic [15:0] rdata [2];
  logic [9:0]  rom_addr;
  logic [15:0] rom_data = 16'd0;
  logic        busy;
  logic [15:0] rom_mem [1024];

  int assertions = 0;
  int failures = 0;
  int cyc = 0;

  // Service model: when each port's ack is due, its data, and when the arbiter frees up
  int          due [2];
  logic [15:0] due_data [2];
  logic [15:0] exp_rdata [2];
  logic [9:0]  exp_rom_addr;
  int          idle_from;
  bit          last;
  bit          model_on = 1'b0;
  logic [1:0]  s_ack;

  os_rom_arb #(.OOR_DATA(OOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(rq[0]), .addr0(ad[0]), .ack0(ack[0]), .rdata0(rdata[0]),
    .req1(rq[1]), .addr1(ad[1]), .ack1(ack[1]), .rdata1(rdata[1]),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [11:0] rand_addr(input bit allow_oor);
    logic [11:0] a;
    a = 12'($urandom);
    a[11] = allow_oor && ($urandom_range(7, 0) == 0);
    return a;
  endfunction

  task automatic model_cycle();
    bit want [2];
    int p;
    logic [11:0] a;
    s_ack = ack;
    for (int i = 0; i < 2; i++) begin
      if (due[i] == cyc) begin
        exp_rdata[i] = due_data[i];
        $display("txn port=%0d cycle=%0d rdata=%h expected=%h", i, cyc, rdata[i], due_data[i]);
      end
      chk($sformatf("ack%0d", i), 32'(ack[i]), 32'(due[i] == cyc));
      chk($sformatf("rdata%0d", i), 32'(rdata[i]), 32'(exp_rdata[i]));
      want[i] = rq[i] && (due[i] != cyc);
    end
    chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    chk("busy", 32'(busy), 32'(cyc < idle_from));
    if (cyc >= idle_from && (want[0] || want[1])) begin
      p = (want[0] && want[1]) ? (last ? 0 : 1) : (want[1] ? 1 : 0);
      a = ad[p];
      last = (p == 1);
      if (a[11]) begin
        due[p] = cyc + 2;
        due_data[p] = OOR;
      end else begin
        due[p] = cyc + 3;
        due_data[p] = rom_mem[a[10:1]];
        exp_rom_addr = a[10:1];
      end
      idle_from = due[p];
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (model_on) model_cycle();
    else s_ack = ack;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    rst_n = 1'b0;
    rq = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata0", 32'(rdata[0]), 32'd0);
    chk("rst_rdata1", 32'(rdata[1]), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc++;
    due[0] = -100;
    due[1] = -100;
    exp_rdata[0] = 16'd0;
    exp_rdata[1] = 16'd0;
    exp_rom_addr = 10'd0;
    idle_from = cyc;
    last = 1'b1;
    model_on = 1'b1;
  endtask

  task automatic run_txn(input int port, input logic [11:0] a, input logic [15:0] exp_d,
                         input int exp_lat);
    int n;
    logic [15:0] other;
    other = rdata[1 - port];
    rq[port] = 1'b1;
    ad[port] = a;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (s_ack[port]) begin
        n = i;
        break;
      end
    end
    rq[port] = 1'b0;
    chk("latency", 32'(n - 1), 32'(exp_lat));
    chk("txn_rdata", 32'(rdata[port]), 32'(exp_d));
    chk("other_rdata_held", 32'(rdata[1 - port]), 32'(other));
    step();
    chk("ack_one_cycle", 32'(s_ack), 32'd0);
    step();
    chk("ack_masking_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int          port;
    logic [11:0] addr;
    logic [15:0] data;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acks, last_t, last_p, p;
    int gap [2];

    ad[0] = 12'd0;
    ad[1] = 12'd0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'($urandom);
    rom_mem[10'h123] = 16'hA5C3;
    rom_mem[10'h07F] = 16'h1234;
    rom_mem[10'h3FF] = 16'hBEEF;
    rom_mem[10'h000] = 16'h0F0F;

    vecs[0] = '{0, 12'h246, 16'hA5C3, 3};
    vecs[1] = '{1, 12'h802, 16'hFFFF, 2};
    vecs[2] = '{1, 12'h0FE, 16'h1234, 3};
    vecs[3] = '{0, 12'hFFF, 16'hFFFF, 2};
    vecs[4] = '{0, 12'h7FF, 16'hBEEF, 3};
    vecs[5] = '{1, 12'h000, 16'h0F0F, 3};

    do_reset();
    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].port, vecs[v].addr, vecs[v].data, vecs[v].lat);
      if (v == 0) chk("rdata1_untouched", 32'(rdata[1]), 32'd0);
    end

    // Simultaneous first requests, then sustained contention
    do_reset();
    rq = 2'b11;
    ad[0] = 12'h010;
    ad[1] = 12'h020;
    acks = 0;
    last_t = 0;
    last_p = 0;
    for (int i = 0; i < 100 && acks < 13; i++) begin
      step();
      if (i == 0) chk("first_grant_rom_addr", 32'(rom_addr), 32'h008);
      if (s_ack != 2'b00) begin
        p = s_ack[1] ? 1 : 0;
        chk("single_ack", 32'(s_ack == 2'b11), 32'd0);
        if (acks == 0) begin
          chk("first_ack_port", 32'(p), 32'd0);
          chk("second_grant_rom_addr", 32'(rom_addr), 32'h010);
        end else begin
          chk("ack_spacing", 32'(cyc - 1 - last_t), 32'd3);
          chk("alternation", 32'(p), 32'(1 - last_p));
        end
        last_t = cyc - 1;
        last_p = p;
        acks++;
        ad[p] = rand_addr(1'b0);
      end
    end
    chk("contention_count", 32'(acks), 32'd13);
    rq = 2'b00;
    repeat (5) step();
    chk("contention_drain_idle", 32'(busy), 32'd0);

    // Random traffic against the service model
    gap[0] = 0;
    gap[1] = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      for (int q = 0; q < 2; q++) begin
        if (s_ack[q]) begin
          if ($urandom_range(1, 0) == 1) ad[q] = rand_addr(1'b1);
          else begin
            rq[q] = 1'b0;
            gap[q] = $urandom_range(3, 0);
          end
        end else if (!rq[q]) begin
          if (gap[q] == 0) begin
            rq[q] = 1'b1;
            ad[q] = rand_addr(1'b1);
          end else gap[q]--;
        end
      end
    end
    rq = 2'b00;
    repeat (5) step();

    // Reset asserted while the FSM is in ADDR
    rq[1] = 1'b1;
    ad[1] = 12'h100;
    step();
    chk("busy_in_addr", 32'(busy), 32'd1);
    chk("addr_state_rom_addr", 32'(rom_addr), 32'h080);
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_rdata0", 32'(rdata[0]), 32'd0);
    chk("async_rst_rdata1", 32'(rdata[1]), 32'd0);
    chk("async_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    do_reset();
    repeat (6) step();
    run_txn(1, 12'h246, 16'hA5C3, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
